// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the execute stage.
//   ALU_*      : alu_func operation codes (10-15 unused, produce 0)
//   ex_state_t : multiply FSM states
//   cnt_width  : bit width of a counter able to hold the value WIDTH
package ex_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } ex_state_t;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: iterative shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start         : load operands, clear accumulator, counter = WIDTH
//   stall         : hold the final step while the result cannot be taken
//   multiplicand  : operand A
//   multiplier    : operand B
//   product       : low WIDTH bits of A*B, valid while done is high
//   done          : combinational pulse on the final (counter == 1) step
module ex_mul_iter
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] product,
  output logic             done
);

  localparam int unsigned CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt;
  logic             last;

  // The final step's sum is presented directly as the product so the
  // result can be registered by the parent on the same edge.
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
    last     = (cnt == CW'(1));
    done     = last && !stall;
    product  = acc_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= multiplicand;
      mplier <= multiplier;
      cnt    <= CW'(WIDTH);
    end else if ((cnt != '0) && !(last && stall)) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: registered, valid/ready handshaked execute stage.
// Build option: define EX_MUL_EN to include the iterative multiplier
// (mul_req selects it); without it mul_req is ignored and busy is 0.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : upstream handshake
//   immediate, rs1, rs2   : operands (rs2 also store data)
//   pc                    : instruction address
//   alu_src               : 1 = immediate as operand B, 0 = rs2
//   alu_func              : ALU operation code
//   mul_req               : multiply rs1 * B (low WIDTH bits)
//   out_valid / out_ready : downstream handshake
//   data1                 : ALU / multiply result
//   data2                 : registered rs2
//   pc_out                : pc + (immediate << BR_SHIFT)
//   zero                  : data1 == 0
//   busy                  : multiply in progress
module ex_stage_pipe
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned BR_SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] immediate,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [WIDTH-1:0] pc,
  input  logic             alu_src,
  input  logic [3:0]       alu_func,
  input  logic             mul_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data1,
  output logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] pc_out,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] br_target;
  logic [SHW-1:0]   shamt;
  logic             accept;
  logic             use_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  always_comb begin
    op_b      = alu_src ? immediate : rs2;
    shamt     = op_b[SHW-1:0];
    br_target = pc + (immediate << BR_SHIFT);
    alu_res   = '0;
    case (alu_func)
      ALU_ADD:  alu_res = rs1 + op_b;
      ALU_SUB:  alu_res = rs1 - op_b;
      ALU_AND:  alu_res = rs1 & op_b;
      ALU_OR:   alu_res = rs1 | op_b;
      ALU_XOR:  alu_res = rs1 ^ op_b;
      ALU_SLL:  alu_res = rs1 << shamt;
      ALU_SRL:  alu_res = rs1 >> shamt;
      ALU_SRA:  alu_res = $signed(rs1) >>> shamt;
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(rs1) < $signed(op_b))};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (rs1 < op_b)};
      default:  alu_res = '0;
    endcase
  end

`ifdef EX_MUL_EN
  ex_state_t state;
  ex_state_t state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept && mul_req) state_next = ST_MUL;
      ST_MUL:  if (mul_done)          state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == ST_MUL);
    in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    use_mul  = mul_req;
  end

  ex_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk          (clk),
    .rst          (rst),
    .start        (accept && mul_req),
    .stall        (out_valid && !out_ready),
    .multiplicand (rs1),
    .multiplier   (op_b),
    .product      (mul_product),
    .done         (mul_done)
  );
`else
  logic unused_mul_req;

  always_comb begin
    busy           = 1'b0;
    in_ready       = !out_valid || out_ready;
    use_mul        = 1'b0;
    mul_done       = 1'b0;
    mul_product    = '0;
    unused_mul_req = mul_req;
  end
`endif

  always_comb accept = in_valid && in_ready;

  // Accept is only possible when the slot is empty or being drained, so
  // data2/pc_out can be loaded at accept for both ALU and multiply ops;
  // a multiply leaves out_valid low until its final step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      data1     <= '0;
      data2     <= '0;
      pc_out    <= '0;
      zero      <= 1'b0;
    end else if (accept) begin
      data2  <= rs2;
      pc_out <= br_target;
      if (use_mul) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= 1'b1;
        data1     <= alu_res;
        zero      <= (alu_res == '0);
      end
    end else if (mul_done) begin
      out_valid <= 1'b1;
      data1     <= mul_product;
      zero      <= (mul_product == '0);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
